// File: rtl/dh_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dh_pkg : shared FSM state, default width and latency constant    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package dh_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      EXP_A = 3'd1,
      PUB   = 3'd2,
      EXP_K = 3'd3,
      DONE  = 3'd4
   } dh_state_e;

   localparam int DH_W_DEFAULT = 8;

   // Cycles from accepted start (or peer) to the corresponding valid.
   function automatic int dh_latency(input int w);
      return 2 * w * (w + 1) + 2;
   endfunction

   localparam int DH_LATENCY = dh_latency(DH_W_DEFAULT);

endpackage
`default_nettype wire

// File: rtl/dh_modmul.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dh_modmul : MSB-first shift-add modular multiplier, a*b mod m    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module dh_modmul
   import dh_pkg::*;
#(
   parameter int W = DH_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] m,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int CW = $clog2(W);

   logic [W-1:0]  a_q, b_q, m_q, r_q;
   logic [CW-1:0] cnt_q;
   logic          run_q, done_q;

   logic [W:0]    dbl_d, sum_d;
   logic [W-1:0]  dbl_red_d, sum_red_d, first_d;

   // a is kept reduced (< m), so one conditional subtract per step suffices.
   always_comb begin
      dbl_d     = {r_q, 1'b0};
      dbl_red_d = (dbl_d >= {1'b0, m_q}) ? W'(dbl_d - {1'b0, m_q}) : dbl_d[W-1:0];
      sum_d     = {1'b0, dbl_red_d} + (b_q[W-1] ? {1'b0, a_q} : '0);
      sum_red_d = (sum_d >= {1'b0, m_q}) ? W'(sum_d - {1'b0, m_q}) : sum_d[W-1:0];
      first_d   = b[W-1] ? ((a >= m) ? a - m : a) : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= '0;
         b_q    <= '0;
         m_q    <= '0;
         r_q    <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (clr) begin
            a_q   <= '0;
            r_q   <= '0;
            run_q <= 1'b0;
         end else if (start) begin
            // The load edge already consumes the top multiplier bit.
            a_q   <= a;
            b_q   <= b << 1;
            m_q   <= m;
            r_q   <= first_d;
            cnt_q <= CW'(W - 1);
            run_q <= 1'b1;
         end else if (run_q) begin
            r_q   <= sum_red_d;
            b_q   <= b_q << 1;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               run_q  <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign done   = done_q;
   assign result = r_q;

endmodule
`default_nettype wire

// File: rtl/dh_key_exchange.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dh_key_exchange : constant-time Diffie-Hellman A=g^a, K=B^a mod p|
// | Optional parameter/peer range checks: DH_PARAM_CHECK_EN. Rev 1.0 |
// +-----------------------------------------------------------------+
module dh_key_exchange
   import dh_pkg::*;
#(
   parameter int W = DH_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] g,
   input  logic [W-1:0] p,
   input  logic [W-1:0] a,
   output logic [W-1:0] pub,
   output logic         pub_valid,
   input  logic [W-1:0] peer,
   input  logic         peer_valid,
   output logic [W-1:0] key,
   output logic         key_valid,
   output logic         busy,
   output logic         err
);

   localparam int CW = $clog2(W);

   dh_state_e     state_q;
   logic [W-1:0]  base_q, p_q, a_q, e_q, acc_q, pub_q, key_q;
   logic [CW-1:0] cnt_q;
   logic          mul_q, issue_q, fin_q, mm_start_q;
   logic          pub_valid_q, key_valid_q, busy_q;

   logic          mm_done, start_bad, peer_bad, kill;
   logic [W-1:0]  mm_res, mm_b;

`ifdef DH_PARAM_CHECK_EN
   logic err_q;

   assign start_bad = (p < W'(3)) || !p[0] || (g < W'(2)) || (g > p - W'(2));
   assign peer_bad  = (peer < W'(2)) || (peer > p_q - W'(2));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= !abort &&
                         ((((state_q == IDLE) || (state_q == DONE)) && start && start_bad) ||
                          ((state_q == PUB) && peer_valid && peer_bad));
   end

   assign err = err_q;
`else
   assign start_bad = 1'b0;
   assign peer_bad  = 1'b0;
   assign err       = 1'b0;
`endif

   assign kill = abort || ((state_q == PUB) && peer_valid && peer_bad);
   assign mm_b = mul_q ? base_q : acc_q;

   dh_modmul #(.W(W)) u_mm (
      .clk    (clk),
      .rst    (rst),
      .clr    (kill),
      .start  (mm_start_q),
      .a      (acc_q),
      .b      (mm_b),
      .m      (p_q),
      .done   (mm_done),
      .result (mm_res)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         p_q         <= '0;
         a_q         <= '0;
         e_q         <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         mul_q       <= 1'b0;
         issue_q     <= 1'b0;
         fin_q       <= 1'b0;
         mm_start_q  <= 1'b0;
         pub_q       <= '0;
         key_q       <= '0;
         pub_valid_q <= 1'b0;
         key_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mm_start_q <= 1'b0;
         if (kill) begin
            state_q     <= IDLE;
            base_q      <= '0;
            a_q         <= '0;
            e_q         <= '0;
            acc_q       <= '0;
            pub_q       <= '0;
            key_q       <= '0;
            mul_q       <= 1'b0;
            issue_q     <= 1'b0;
            fin_q       <= 1'b0;
            pub_valid_q <= 1'b0;
            key_valid_q <= 1'b0;
            busy_q      <= 1'b0;
         end else begin
            case (state_q)
               IDLE, DONE: begin
                  if (start) begin
                     key_valid_q <= 1'b0;
                     if (start_bad) begin
                        state_q <= IDLE;
                     end else begin
                        state_q <= EXP_A;
                        base_q  <= g;
                        p_q     <= p;
                        a_q     <= a;
                        e_q     <= a;
                        acc_q   <= W'(1);
                        cnt_q   <= CW'(W - 1);
                        mul_q   <= 1'b0;
                        issue_q <= 1'b1;
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               EXP_A, EXP_K: begin
                  if (issue_q) begin
                     issue_q    <= 1'b0;
                     mm_start_q <= 1'b1;
                  end else if (fin_q) begin
                     fin_q <= 1'b0;
                     if (state_q == EXP_A) begin
                        pub_q       <= acc_q;
                        pub_valid_q <= 1'b1;
                        state_q     <= PUB;
                     end else begin
                        key_q       <= acc_q;
                        key_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                     end
                  end else if (mm_done) begin
                     // Multiply always runs; its result is dropped for a 0 bit.
                     if (!mul_q) begin
                        acc_q      <= mm_res;
                        mul_q      <= 1'b1;
                        mm_start_q <= 1'b1;
                     end else begin
                        if (e_q[W-1]) acc_q <= mm_res;
                        e_q   <= e_q << 1;
                        mul_q <= 1'b0;
                        if (cnt_q == '0) begin
                           fin_q <= 1'b1;
                        end else begin
                           cnt_q      <= cnt_q - 1'b1;
                           mm_start_q <= 1'b1;
                        end
                     end
                  end
               end
               PUB: begin
                  if (peer_valid) begin
                     state_q     <= EXP_K;
                     base_q      <= peer;
                     pub_valid_q <= 1'b0;
                     e_q         <= a_q;
                     acc_q       <= W'(1);
                     cnt_q       <= CW'(W - 1);
                     mul_q       <= 1'b0;
                     issue_q     <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign pub       = pub_q;
   assign pub_valid = pub_valid_q;
   assign key       = key_q;
   assign key_valid = key_valid_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: doc/dh_key_exchange.md
DH_KEY_EXCHANGE -- requirements
Module: dh_key_exchange

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width of g, p, a, B, A and K in bits (W >= 4).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse that begins a key exchange.
REQ-005 SHALL have port abort  input  1  cancels any exchange and zeroizes secrets.
REQ-006 SHALL have ports g, p, a  input  W each  generator, prime modulus and private exponent, sampled with start.
REQ-007 SHALL have port pub  output  W  own public key A = g^a mod p.
REQ-008 SHALL have port pub_valid  output  1  pub holds A.
REQ-009 SHALL have ports peer  input  W  and  peer_valid  input  1  peer public key B and its qualifier.
REQ-010 SHALL have port key  output  W  shared secret K = B^a mod p.
REQ-011 SHALL have port key_valid  output  1  key holds K.
REQ-012 SHALL have ports busy  output  1  and  err  output  1  (exchange in progress; parameter rejected).

Function
REQ-013 SHALL implement FSM states IDLE, EXP_A, PUB, EXP_K, DONE.
REQ-014 IDLE + start: SHALL register g, p, a and enter EXP_A; busy high from the next cycle until IDLE or DONE.
REQ-015 Exponentiation SHALL be MSB-first square-and-multiply over all W exponent bits, always performing both products (constant time) and discarding the multiply when the bit is 0; accumulator starts at 1.
REQ-016 Each modular product SHALL take exactly W+1 cycles; start-to-pub_valid and peer-accept-to-key_valid latency SHALL each be exactly 2W(W+1)+2 cycles (146 for W=8).
REQ-017 All intermediate values SHALL be fully reduced (< p); no intermediate SHALL exceed W+1 bits.
REQ-018 In PUB, pub_valid SHALL stay high with pub stable until peer_valid is sampled high; then peer SHALL be registered, pub_valid cleared, and EXP_K entered.
REQ-019 In DONE, key_valid SHALL stay high with key stable until start or abort.
REQ-020 start outside IDLE/DONE SHALL be ignored; start in DONE SHALL clear key_valid and begin a new exchange as from IDLE.
REQ-021 peer_valid outside PUB SHALL be ignored.
REQ-022 abort SHALL force IDLE on the next edge, clear pub_valid, key_valid and busy, and zero the registered a, accumulator and key; abort SHALL win over a simultaneous start.
REQ-023 a = 0 SHALL yield pub = 1; peer = 1 SHALL yield key = 1.

Reset
REQ-024 On rst low, state SHALL be IDLE and pub, key, pub_valid, key_valid, busy and err SHALL be 0, asynchronously.
REQ-025 Reset mid-exchange SHALL discard all work; no output SHALL assert until a new start after release.

Configuration
REQ-026 With DH_PARAM_CHECK_EN defined, start SHALL be rejected when p < 3, p even, or g not in [2, p-2]; rejection SHALL pulse err for one cycle and leave the FSM in IDLE. Likewise peer outside [2, p-2] in PUB SHALL pulse err, zeroize as in REQ-022, and return to IDLE.
REQ-027 Without DH_PARAM_CHECK_EN, err SHALL be tied 0, no checks SHALL be performed, and results for out-of-range parameters are unspecified.

Structure
REQ-028 A shared package dh_pkg SHALL hold the FSM state enum, the default W, and the latency formula constant.
REQ-029 A sub-module dh_modmul (sequential shift-add modular multiplier: start, done, a, b, m, result; W+1 cycles) SHALL perform all products.

Verification
REQ-030 W=8: g=5, p=23, a=6, start -> pub=8 with pub_valid exactly 146 cycles after start.
REQ-031 Then peer=19 with peer_valid -> key=2 with key_valid 146 cycles later, held until start.
REQ-032 a=0, g=5, p=23 -> pub=1; peer=1 -> key=1.
REQ-033 abort asserted in EXP_A cycle 50 together with start -> IDLE next cycle, all outputs 0, internal a=0, no pub_valid.
REQ-034 rst low mid EXP_K -> outputs 0 immediately; after release, no key_valid without a new start.
REQ-035 DH_PARAM_CHECK_EN defined: p=22 or g=1 with start -> err one-cycle pulse, busy stays 0; undefined: err constant 0.
